// File: rtl/tt_um_delta_decoder_pkg.sv
// Shared definitions for the delta decoder: state encoding and uio bit map.
package tt_um_delta_decoder_pkg;

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } state_t;

    localparam int STB    = 0;
    localparam int SEED   = 1;
    localparam int SAT    = 2;
    localparam int OVAL   = 4;
    localparam int OVF    = 5;
    localparam int UNF    = 6;
    localparam int SEEDED = 7;

    localparam int         SYNC_W     = 3;
    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/tt_um_delta_decoder_sync_edge.sv
// Two-flop synchronizer for a control bus plus a history flop on one bit
// for rising-edge detection.
module tt_sync_edge #(
    parameter int W        = 3,
    parameter int EDGE_BIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sync,
    output logic         o_edge
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic         r_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_hist <= 1'b0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_hist <= r_s2[EDGE_BIT];
        end
    end

    assign o_sync = r_s2;
    assign o_edge = r_s2[EDGE_BIT] & ~r_hist;

endmodule

// File: rtl/tt_um_delta_decoder.sv
// Delta decoder: reconstructs an 8-bit value from a seed plus signed deltas
// delivered by a strobed host interface on the uio pins.
module tt_um_delta_decoder
    import tt_um_delta_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_acc;
    logic [7:0]  w_acc_nx;
    logic        r_ovf;
    logic        w_ovf_nx;
    logic        r_unf;
    logic        w_unf_nx;
    logic        r_oval;
    logic        w_oval_nx;

    logic [SYNC_W-1:0] w_sync;
    logic              w_edge;
    logic [9:0]        w_sum;
    logic [7:0]        w_uio;
    logic              w_unused;

    tt_sync_edge #(
        .W        (SYNC_W),
        .EDGE_BIT (STB)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (uio_in[SYNC_W-1:0]),
        .o_sync (w_sync),
        .o_edge (w_edge)
    );

    // Range is -128..382, so bit 9 is the sign and bit 8 flags > 255.
    assign w_sum = {2'b00, r_acc} + {{2{ui_in[7]}}, ui_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= UNSEEDED;
            r_acc   <= 8'h00;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_oval  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
            r_ovf   <= w_ovf_nx;
            r_unf   <= w_unf_nx;
            r_oval  <= w_oval_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_ovf_nx   = r_ovf;
        w_unf_nx   = r_unf;
        w_oval_nx  = 1'b0;
        if (w_edge) begin
            priority case (1'b1)
                w_sync[SEED]: begin
                    w_state_nx = RUN;
                    w_acc_nx   = ui_in;
                    w_ovf_nx   = 1'b0;
                    w_unf_nx   = 1'b0;
                    w_oval_nx  = 1'b1;
                end
                (r_state == RUN): begin
                    w_oval_nx = 1'b1;
                    w_acc_nx  = w_sum[7:0];
                    if (w_sum[9]) begin
                        w_unf_nx = 1'b1;
                        if (w_sync[SAT]) w_acc_nx = 8'h00;
                    end else if (w_sum[8]) begin
                        w_ovf_nx = 1'b1;
                        if (w_sync[SAT]) w_acc_nx = 8'hFF;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_uio         = 8'h00;
        w_uio[OVAL]   = r_oval;
        w_uio[OVF]    = r_ovf;
        w_uio[UNF]    = r_unf;
        w_uio[SEEDED] = (r_state == RUN);
    end

    assign uo_out   = r_acc;
    assign uio_out  = w_uio;
    assign uio_oe   = UIO_OE_VAL;
    assign w_unused = &{1'b0, ena, uio_in[7:3], w_sync[STB]};

endmodule

// File: tb/tb_tt_um_delta_decoder.sv
// Directed vector bench for tt_um_delta_decoder: table of transfers plus
// hand-written timing and reset sequences.
module tb_tt_um_delta_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_um_delta_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        logic       sd;
        logic       st;
        logic [7:0] d;
        logic [7:0] acc;
        logic       ovf;
        logic       unf;
        logic       sdd;
        int         nv;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // One full host transfer; counts out_valid cycles seen.
    task automatic xfer(input logic sd, input logic st,
                        input logic [7:0] d, output int nv);
        nv = 0;
        @(negedge clk);
        ui_in     = d;
        uio_in[1] = sd;
        uio_in[2] = st;
        @(negedge clk);
        uio_in[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (uio_out[4]) nv++;
        end
        uio_in[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (uio_out[4]) nv++;
        end
    endtask

    function automatic vec_t mk(input logic sd, input logic st,
                                input logic [7:0] d, input logic [7:0] acc,
                                input logic ovf, input logic unf,
                                input logic sdd, input int nv);
        vec_t v;
        v.sd = sd; v.st = st; v.d = d; v.acc = acc;
        v.ovf = ovf; v.unf = unf; v.sdd = sdd; v.nv = nv;
        return v;
    endfunction

    initial begin
        int nv;
        int cnt;

        tbl[0]  = mk(0, 0, 8'd5,   8'd0,   0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 8'd7,   8'd7,   0, 0, 1, 1);
        tbl[2]  = mk(1, 0, 8'd100, 8'd100, 0, 0, 1, 1);
        tbl[3]  = mk(0, 0, 8'd20,  8'd120, 0, 0, 1, 1);
        tbl[4]  = mk(0, 0, 8'hCE,  8'd70,  0, 0, 1, 1);
        tbl[5]  = mk(1, 0, 8'd250, 8'd250, 0, 0, 1, 1);
        tbl[6]  = mk(0, 0, 8'd10,  8'd4,   1, 0, 1, 1);
        tbl[7]  = mk(1, 0, 8'd3,   8'd3,   0, 0, 1, 1);
        tbl[8]  = mk(0, 1, 8'hFB,  8'd0,   0, 1, 1, 1);
        tbl[9]  = mk(1, 0, 8'd250, 8'd250, 0, 0, 1, 1);
        tbl[10] = mk(0, 1, 8'd10,  8'd255, 1, 0, 1, 1);
        tbl[11] = mk(0, 0, 8'hFF,  8'd254, 1, 0, 1, 1);
        tbl[12] = mk(0, 0, 8'hFF,  8'd253, 1, 0, 1, 1);
        tbl[13] = mk(1, 0, 8'd128, 8'd128, 0, 0, 1, 1);
        tbl[14] = mk(0, 0, 8'h7F,  8'd255, 0, 0, 1, 1);
        tbl[15] = mk(0, 0, 8'h80,  8'd127, 0, 0, 1, 1);
        tbl[16] = mk(1, 0, 8'd3,   8'd3,   0, 0, 1, 1);
        tbl[17] = mk(0, 0, 8'hFB,  8'd254, 0, 1, 1, 1);
        tbl[18] = mk(0, 0, 8'd2,   8'd0,   1, 1, 1, 1);
        tbl[19] = mk(1, 0, 8'd0,   8'd0,   0, 0, 1, 1);

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_acc", uo_out, 0);
        chk("reset_uio_out", uio_out, 0);
        chk("reset_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            xfer(tbl[i].sd, tbl[i].st, tbl[i].d, nv);
            chk($sformatf("v%0d_acc", i), uo_out, tbl[i].acc);
            chk($sformatf("v%0d_ovf", i), uio_out[5], tbl[i].ovf);
            chk($sformatf("v%0d_unf", i), uio_out[6], tbl[i].unf);
            chk($sformatf("v%0d_seeded", i), uio_out[7], tbl[i].sdd);
            chk($sformatf("v%0d_oval_cnt", i), nv, tbl[i].nv);
            chk($sformatf("v%0d_low", i), uio_out[3:0], 0);
            chk($sformatf("v%0d_oe", i), uio_oe, 8'hF0);
        end

        // Exact latency, then a long-held strobe must not retrigger.
        @(negedge clk);
        ui_in  = 8'd10;
        uio_in = 8'h00;
        @(negedge clk);
        uio_in[0] = 1'b1;
        @(posedge clk); #1;
        chk("lat_n0_acc", uo_out, 0);
        @(posedge clk); #1;
        chk("lat_n1_acc", uo_out, 0);
        chk("lat_n1_oval", uio_out[4], 0);
        @(posedge clk); #1;
        chk("lat_n2_acc", uo_out, 10);
        chk("lat_n2_oval", uio_out[4], 1);
        @(posedge clk); #1;
        chk("lat_n3_oval", uio_out[4], 0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (uio_out[4]) cnt++;
        end
        chk("hold_oval_cnt", cnt, 0);
        chk("hold_acc", uo_out, 10);
        uio_in[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a delta transfer from RUN.
        xfer(1'b1, 1'b0, 8'd50, nv);
        chk("abort_seed_acc", uo_out, 50);
        @(negedge clk);
        ui_in  = 8'd5;
        uio_in = 8'h00;
        @(negedge clk);
        uio_in[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_oe", uio_oe, 8'hF0);
        uio_in[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (uio_out[4]) cnt++;
        end
        chk("abort_oval_cnt", cnt, 0);
        chk("abort_acc", uo_out, 0);
        chk("abort_seeded", uio_out[7], 0);
        chk("abort_oe_after", uio_oe, 8'hF0);

        // Strobe already high as reset releases.
        @(negedge clk);
        rst_n  = 1'b0;
        ui_in  = 8'd9;
        uio_in = 8'h03;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_r0_acc", uo_out, 0);
        @(posedge clk); #1;
        chk("rel_r1_acc", uo_out, 0);
        @(posedge clk); #1;
        chk("rel_r2_acc", uo_out, 9);
        chk("rel_r2_seeded", uio_out[7], 1);
        chk("rel_r2_oval", uio_out[4], 1);
        @(negedge clk);
        uio_in = 8'h00;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_delta_decoder.md
TT_UM_DELTA_DECODER -- requirements
Module: tt_um_delta_decoder

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port ena, input, 1: powered indication; ignored.
REQ-004 SHALL have port ui_in, input, 8: a delta (two's complement, -128..127) or, in a seed transfer, an absolute seed value (unsigned).
REQ-005 SHALL have port uio_in, input, 8: bit 0 = strobe, bit 1 = seed qualifier, bit 2 = saturate enable; bits 7:3 unused.
REQ-006 SHALL have port uo_out, output, 8: the reconstructed value, i.e. the accumulator (unsigned 0..255).
REQ-007 SHALL have port uio_out, output, 8: bit 4 = out_valid, bit 5 = ovf sticky, bit 6 = unf sticky, bit 7 = seeded; bits 3:0 = 0.
REQ-008 SHALL have port uio_oe, output, 8: constant 8'hF0.

Function
REQ-009 SHALL pass uio_in[2:0] through a 2-flop synchronizer plus a 3rd history flop, and detect a strobe rising edge as sync2 & ~sync3.
REQ-010 SHALL act on each detected edge at the next clock edge, using the synchronized seed and saturate bits and the ui_in value sampled at that edge.
REQ-011 SHALL update the accumulator at clock edge N+2, where N is the first edge that samples uio_in[0] high.
REQ-012 SHALL drive out_valid high for exactly the one cycle following an update.
REQ-013 Host contract: ui_in and uio_in[2:1] stable from 1 cycle before the strobe rises until it falls; strobe high >= 2 cycles and low >= 2 cycles; otherwise behaviour is undefined.
REQ-014 SHALL implement states UNSEEDED (reset state) and RUN; the seeded flag SHALL equal (state == RUN).
REQ-015 SHALL, on an edge with seed=1 in either state, load acc = ui_in, clear ovf and unf, enter RUN, and pulse out_valid.
REQ-016 SHALL, on an edge with seed=0 in UNSEEDED, leave acc, flags and out_valid unchanged.
REQ-017 SHALL, on an edge with seed=0 in RUN, compute a 10-bit signed sum = {2'b00,acc} + sign-extended ui_in.
REQ-018 SHALL, when the sum > 255: set ovf; acc = 255 if saturate=1, else acc = sum[7:0].
REQ-019 SHALL, when the sum < 0: set unf; acc = 0 if saturate=1, else acc = sum[7:0].
REQ-020 SHALL keep ovf and unf sticky until a seed transfer or reset; both may be set simultaneously.
REQ-021 SHALL drive uo_out directly from the accumulator register, with no combinational path from ui_in.

Reset
REQ-022 SHALL, with rst_n low at a clock edge: acc = 0; state = UNSEEDED; ovf, unf and out_valid = 0; all synchronizer and history flops = 0.
REQ-023 SHALL let reset asserted mid-transfer abort the transfer, so that no update occurs from a strobe already in the synchronizer.
REQ-024 SHALL, when the strobe is already high as reset releases, treat it as a new rising edge 2 cycles after release.

Structure
REQ-025 SHALL place in a shared package/include: the state encoding, the uio bit-index constants (STB=0, SEED=1, SAT=2, OVAL=4, OVF=5, UNF=6, SEEDED=7) and UIO_OE_VAL = 8'hF0.
REQ-026 SHALL implement the synchronizer and edge detector as one sub-module, tt_sync_edge, parameterized by width (3 here), with outputs for the synced bits and the edge pulse.

Verification
REQ-027 Seed 8'd100, then deltas +20, -50 -> uo_out 100, 120, 70; out_valid one cycle per transfer; seeded=1.
REQ-028 Delta +5 sent before any seed -> uo_out stays 0, seeded=0, no out_valid pulse; a later seed 8'd7 -> uo_out 7.
REQ-029 Seed 250, delta +10 with saturate=0 -> uo_out 4, ovf=1; then seed 3, delta -5 with saturate=1 -> uo_out 0, unf=1, ovf=0.
REQ-030 Strobe sampled high at edge N -> uo_out changes at edge N+2 exactly; no update for a strobe held high for 10 cycles beyond the first.
REQ-031 rst_n low at edge N+1 of a delta transfer from state RUN, acc 50 -> acc 0, UNSEEDED, no out_valid; uio_oe = 8'hF0 throughout.
REQ-032 Flags stick: ovf set, then deltas -1, -1 -> ovf stays 1 until the next seed clears it.
